// File: rtl/trng_postproc.sv
// trng_postproc: von Neumann corrector, word packer and valid/ready output for the TRNG.
// Define TRNG_HEALTH_EN to build the repetition-count health test that blocks output.
module trng_postproc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_bit,
  input  logic             en,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             health_fail
);

  localparam int unsigned SH_W  = WIDTH - 1;
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || REP_LIMIT < 2) begin : g_param_check
    $error("trng_postproc: WIDTH and REP_LIMIT must both be at least 2");
  end

  typedef enum logic {FIRST, SECOND} pair_state_e;

  pair_state_e      pstate;
  logic             a_bit;
  logic [SH_W-1:0]  shift;
  logic [CNT_W-1:0] count;
  logic             emit_c;
  logic             word_done_c;
  logic             free_c;
  logic             block_c;
  logic             load_c;

  // Corrected bit is the stored first sample of an unequal pair.
  always_comb begin
    emit_c      = en && (pstate == SECOND) && (a_bit != raw_bit);
    word_done_c = emit_c && (count == CNT_LAST);
    free_c      = !valid || ready;
    load_c      = word_done_c && free_c && !block_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate <= FIRST;
      a_bit  <= 1'b0;
      shift  <= '0;
      count  <= '0;
      data   <= '0;
      valid  <= 1'b0;
    end else begin
      if (!en) begin
        pstate <= FIRST;
      end else if (pstate == FIRST) begin
        a_bit  <= raw_bit;
        pstate <= SECOND;
      end else begin
        pstate <= FIRST;
      end

      if (emit_c && !word_done_c) begin
        shift <= SH_W'({shift, a_bit});
        count <= count + CNT_W'(1);
      end

      // A completed word that cannot be delivered is dropped and count parks at the last slot.
      if (load_c) begin
        data  <= {shift, a_bit};
        valid <= 1'b1;
        count <= '0;
      end else if (block_c || ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int unsigned RUN_W = $clog2(REP_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(REP_LIMIT);

  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_next_c;
  logic             last_bit;

  // Run length of identical enabled samples, saturating at the trip point.
  always_comb begin
    run_next_c = run;
    if (run == '0 || raw_bit != last_bit) begin
      run_next_c = RUN_W'(1);
    end else if (run != RUN_LIMIT) begin
      run_next_c = run + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (en) begin
      run      <= run_next_c;
      last_bit <= raw_bit;
      if (run_next_c == RUN_LIMIT) begin
        health_fail <= 1'b1;
      end
    end
  end

  assign block_c = health_fail;
`else
  assign health_fail = 1'b0;
  assign block_c     = 1'b0;
`endif

endmodule

// File: tb/tb_trng_postproc.sv
// tb_trng_postproc: randomized and directed stimulus checked cycle by cycle against a
// queue-based reference model of the corrector, packer, handshake and health test.
module tb_trng_postproc;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned REP_LIMIT = 32;
`ifdef TRNG_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             raw_bit;
  logic             en;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             health_fail;

  trng_postproc #(.WIDTH(WIDTH), .REP_LIMIT(REP_LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_bit     (raw_bit),
    .en          (en),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit             m_have_a;
  bit             m_a;
  bit             m_bits[$];
  logic [WIDTH-1:0] m_data;
  bit             m_valid;
  bit             m_fail;
  int             m_run;
  bit             m_last;

  // Observation of delivered words for directed checks
  int             pulses;
  logic [WIDTH-1:0] seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_a = 1'b0;
    m_a      = 1'b0;
    m_bits.delete();
    m_data   = '0;
    m_valid  = 1'b0;
    m_fail   = 1'b0;
    m_run    = 0;
    m_last   = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs applied for that edge.
  task automatic model_edge();
    bit emit;
    bit ebit;
    bit loaded;
    bit free;
    logic [WIDTH-1:0] w;
    emit   = 1'b0;
    ebit   = 1'b0;
    loaded = 1'b0;
    if (en) begin
      if (m_have_a) begin
        m_have_a = 1'b0;
        if (m_a != raw_bit) begin
          emit = 1'b1;
          ebit = m_a;
        end
      end else begin
        m_have_a = 1'b1;
        m_a      = raw_bit;
      end
    end else begin
      m_have_a = 1'b0;
    end
    free = !m_valid || ready;
    if (emit) begin
      if (m_bits.size() == WIDTH - 1) begin
        if (free && !m_fail) begin
          w = '0;
          foreach (m_bits[i]) w = {w[WIDTH-2:0], m_bits[i]};
          m_data = {w[WIDTH-2:0], ebit};
          m_bits.delete();
          loaded = 1'b1;
        end
      end else begin
        m_bits.push_back(ebit);
      end
    end
    if (m_fail)                 m_valid = 1'b0;
    else if (loaded)            m_valid = 1'b1;
    else if (m_valid && ready)  m_valid = 1'b0;
    if (HEALTH && en) begin
      if (m_run == 0 || raw_bit != m_last) m_run = 1;
      else                                 m_run = m_run + 1;
      m_last = raw_bit;
      if (m_run >= REP_LIMIT) m_fail = 1'b1;
    end
  endtask

  task automatic compare();
    check("valid", 32'(valid), 32'(m_valid));
    check("data", 32'(data), 32'(m_data));
    check("health_fail", 32'(health_fail), 32'(m_fail));
    if (valid === 1'b1) begin
      pulses++;
      seen = data;
    end
  endtask

  task automatic step(input bit e, input bit r, input bit rdy);
    en      = e;
    raw_bit = r;
    ready   = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  // Reset pulse asserted 1 ns after a falling edge and held for 3 ns.
  task automatic pulse_reset();
    en    = 1'b0;
    ready = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1 compare();
    #2 rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_obs();
    pulses = 0;
    seen   = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    raw_bit = 1'b0;
    ready   = 1'b0;
    model_reset();
    clear_obs();
    @(negedge clk);
    compare();
    rst_n = 1'b1;

    // 1,0 pairs
    clear_obs();
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2) == 0, 1'b1);
    check("word_10", 32'(seen), 32'hFF);
    check("pulses_10", 32'(pulses), 32'd1);
    check("hf_10", 32'(health_fail), 32'd0);

    // 1,0,0,1 pattern
    clear_obs();
    for (int i = 0; i < 16; i++) step(1'b1, ((i % 4) == 0) || ((i % 4) == 3), 1'b1);
    check("word_1001", 32'(seen), 32'hAA);
    check("pulses_1001", 32'(pulses), 32'd1);

    // 0,1 pairs
    clear_obs();
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2) == 1, 1'b1);
    check("word_01", 32'(seen), 32'h00);
    check("pulses_01", 32'(pulses), 32'd1);

    // stuck-at-0 source
    clear_obs();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1);
    check("pulses_const0", 32'(pulses), 32'd0);
    check("hf_const0", 32'(health_fail), 32'(HEALTH));
    pulse_reset();

    // back-pressure: word held, later bits dropped, count parked
    clear_obs();
    for (int i = 0; i < 40; i++) step(1'b1, (i % 2) == 0, 1'b0);
    check("held_valid", 32'(valid), 32'd1);
    check("held_data", 32'(data), 32'hFF);
    step(1'b0, 1'b0, 1'b1);
    check("valid_drop", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    check("one_pair_wait", 32'(valid), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("one_pair_word", 32'(valid), 32'd1);
    step(1'b1, 1'b0, 1'b1);

    // reset after 5 corrected bits, then 8 fresh bits required
    for (int i = 0; i < 10; i++) step(1'b1, (i % 2) == 0, 1'b1);
    pulse_reset();
    clear_obs();
    for (int i = 0; i < 14; i++) step(1'b1, (i % 2) == 0, 1'b1);
    check("pulses_after_rst7", 32'(pulses), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("word_after_rst", 32'(valid), 32'd1);

    // en dropped mid-pair discards the half pair
    clear_obs();
    for (int i = 0; i < 14; i++) step(1'b1, (i % 2) == 0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("en_toggle_word", 32'(seen), 32'hFE);
    check("en_toggle_pulses", 32'(pulses), 32'd1);

    // randomized: unbiased source, then a heavily biased one
    for (int blk = 0; blk < 6; blk++) begin
      pulse_reset();
      for (int i = 0; i < 500; i++) begin
        if (blk % 2 == 0)
          step(($urandom % 8) != 0, $urandom % 2 == 1, $urandom % 2 == 1);
        else
          step(($urandom % 8) != 0, ($urandom % 16) != 0, $urandom % 4 != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trng_postproc.md
# trng_postproc

Downstream conditioning stage of the TRNG. It consumes the single-bit jitter samples produced by the D flip-flop sampler and removes bias with a von Neumann corrector. It packs the corrected bits into WIDTH-bit words and hands them out over a valid/ready interface. An optional repetition-count health test blocks output when the raw source sticks.

## Interface
- WIDTH, default 8: output word width in bits, 2 or more.
- REP_LIMIT, default 32: run length of identical raw samples that trips the health test, 2 or more.

- clk, input, 1: sampling clock; the same clock that drives the sampler flip-flop.
- rst_n, input, 1: asynchronous active-low reset.
- raw_bit, input, 1: sampler Q output, synchronous to clk.
- en, input, 1: sample enable; raw_bit is ignored while en=0.
- data, output, WIDTH: packed random word.
- valid, output, 1: data holds an unconsumed word.
- ready, input, 1: consumer accepts data.
- health_fail, output, 1: sticky health-test failure flag.

## Operation
- Reset state, asynchronous while rst_n=0:
  - data=0, valid=0, health_fail=0.
  - Shift count=0, pair FSM in FIRST, run counter=0.
- Pair FSM, advances only on edges where en=1:
  - FIRST: store raw_bit as bit a, go to SECOND.
  - SECOND: take raw_bit as bit b, go to FIRST.
    - a≠b: emit corrected bit a (pair 10 gives 1, pair 01 gives 0).
    - a=b: discard the pair.
- en=0 forces the FSM to FIRST, so a half pair is discarded. The shift count and the output register are kept.
- Packing:
  - Each emitted bit shifts into the LSB of the shift register, so the first bit of a word ends up in data[WIDTH-1].
  - Count runs 0..WIDTH-1.
  - If count=WIDTH-1 and the output is free, data loads {shift[WIDTH-2:0], bit}, valid goes to 1 and count goes to 0. The output is free when valid=0, or when valid=1 and ready=1 in the same cycle.
  - If count=WIDTH-1 and the output is not free, the emitted bit is dropped and count stays at WIDTH-1. The packer never overwrites an unconsumed word.
- Handshake:
  - The transfer occurs on an edge where valid=1 and ready=1.
  - valid falls after that edge unless a new word loads on the same edge, in which case valid stays 1 with the new data.
  - data is stable while valid=1 and ready=0.
- Health test: see Configuration.

## Timing
- Latency: valid rises on the same edge that samples the second bit of the pair that completes a word.
- Minimum word interval is 2·WIDTH enabled cycles, reached with all pairs unequal.
- Back-to-back output with ready held at 1 keeps valid at 1 only if words arrive on consecutive edges, which is impossible. Every word is therefore a single-cycle valid pulse when ready=1.
- Reset mid-word or mid-transfer: all state clears immediately and the partial word is lost. After release a full fresh word is required.
- Run counter:
  - Counts consecutive identical raw_bit samples on en=1 edges.
  - Restarts at 1 when the value changes.
  - Holds while en=0.

## Configuration
- TRNG_HEALTH_EN defined:
  - Repetition-count test active.
  - On the edge that samples the REP_LIMIT-th consecutive identical bit, health_fail goes to 1 and stays there until reset.
  - While health_fail=1: no new word loads, valid is forced to 0 from the next edge, and the held word is discarded.
- TRNG_HEALTH_EN undefined:
  - No run counter is built.
  - health_fail is tied to 0.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, ready=1, en=1, raw 1,0 repeated for 16 cycles → one-cycle valid, data=8'hFF, health_fail=0.
- Raw 1,0,0,1 repeated for 16 cycles → data=8'hAA; raw 0,1 repeated → data=8'h00.
- Raw constant 0 for 40 cycles:
  - With TRNG_HEALTH_EN: no valid; health_fail=1 from the 32nd sampling edge onward.
  - Without it: no valid; health_fail=0.
- ready=0, raw 1,0 for 40 cycles:
  - data=8'hFF is held with valid=1 and later bits are dropped.
  - Raise ready for 1 cycle → valid falls.
  - The next word needs only 1 new pair, because count has held at 7.
- Reset mid-operation:
  - Emit 5 corrected bits, then pulse rst_n low for 3 ns mid-cycle → data=0 and valid=0 immediately.
  - Next word appears only after 8 further corrected bits.
- en toggle mid-pair: raw 1 with en=1, then en=0 for 1 cycle, then raw 0,1 with en=1 → the corrected bit emitted is 0, not 1.
